// File: rtl/restoring_divider_seq.sv
// restoring_divider_seq: iterative unsigned restoring divider with start/done handshake; `DIV_EARLY_EXIT_EN finishes divisor>dividend in one cycle
module restoring_divider_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [WIDTH:0] r, r_n, t, r_new;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] d, d_n, v, v_n, q, q_n, q_sh, quotient_n, remainder_n;
  logic [CW-1:0] cnt, cnt_n;
  logic busy_n, done_n, dbz_n, borrow;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      r           <= '0;
      d           <= '0;
      v           <= '0;
      q           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_n;
      r           <= r_n;
      d           <= d_n;
      v           <= v_n;
      q           <= q_n;
      cnt         <= cnt_n;
      busy        <= busy_n;
      done        <= done_n;
      quotient    <= quotient_n;
      remainder   <= remainder_n;
      div_by_zero <= dbz_n;
    end
  end
  // trial subtraction one bit wider than the partial remainder so the MSB is the borrow
  assign t      = {r[WIDTH-1:0], d[WIDTH-1]};
  assign diff   = {1'b0, t} - {2'b0, v};
  assign borrow = diff[WIDTH+1];
  assign r_new  = borrow ? t : diff[WIDTH:0];
  assign q_sh   = {q[WIDTH-2:0], ~borrow};
  always_comb begin
    state_n     = state;
    r_n         = r;
    d_n         = d;
    v_n         = v;
    q_n         = q;
    cnt_n       = cnt;
    busy_n      = busy;
    done_n      = 1'b0;
    quotient_n  = quotient;
    remainder_n = remainder;
    dbz_n       = div_by_zero;
    if (state == IDLE && start) begin
      if (divisor == '0) begin
        quotient_n  = '1;
        remainder_n = dividend;
        dbz_n       = 1'b1;
        done_n      = 1'b1;
`ifdef DIV_EARLY_EXIT_EN
      end else if (divisor > dividend) begin
        quotient_n  = '0;
        remainder_n = dividend;
        dbz_n       = 1'b0;
        done_n      = 1'b1;
`endif
      end else begin
        r_n     = '0;
        d_n     = dividend;
        v_n     = divisor;
        q_n     = '0;
        cnt_n   = '0;
        busy_n  = 1'b1;
        dbz_n   = 1'b0;
        state_n = RUN;
      end
    end else if (state == RUN) begin
      r_n   = r_new;
      d_n   = d << 1;
      q_n   = q_sh;
      cnt_n = cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        quotient_n  = q_sh;
        remainder_n = r_new[WIDTH-1:0];
        busy_n      = 1'b0;
        done_n      = 1'b1;
        state_n     = IDLE;
      end
    end
  end
endmodule
